// File: rtl/monitor_bus_capture_pkg.sv
// Shared types and constants for the monitor-strobe capture block.
package monitor_pkg;

    localparam int NUM_STB    = 15;
    localparam int STB_MWG    = 0;
    localparam int STB_MWAG   = 1;
    localparam int STB_MWLG   = 2;
    localparam int STB_MWQG   = 3;
    localparam int STB_MWZG   = 4;
    localparam int STB_MWBG   = 5;
    localparam int STB_MWSG   = 6;
    localparam int STB_MWYG   = 7;
    localparam int STB_MWEBG  = 8;
    localparam int STB_MWFBG  = 9;
    localparam int STB_MWBBEG = 10;
    localparam int STB_MRAG   = 11;
    localparam int STB_MRGG   = 12;
    localparam int STB_MRLG   = 13;
    localparam int STB_MRULOG = 14;

    localparam logic [3:0] STATUS_SEL = 4'hF;

    typedef struct packed {
        logic [14:0] mask;
        logic [15:0] data;
    } mon_evt_t;

endpackage

// File: rtl/monitor_bus_capture_if.sv
// Capture-event stream: producer (master) presents FIFO head, consumer (slave) accepts it.
interface monitor_bus_capture_if;
    import monitor_pkg::*;

    logic                 evt_valid;
    logic                 evt_ready;
    logic [NUM_STB-1:0]   evt_mask;
    logic [15:0]          evt_data;

    modport master (output evt_valid, output evt_mask, output evt_data, input evt_ready);
    modport slave  (input evt_valid, input evt_mask, input evt_data, output evt_ready);

endinterface

// File: rtl/monitor_bus_capture_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO without a pop is dropped and flagged.
module mon_evt_fifo
    import monitor_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  mon_evt_t      push_data_i,
    input  logic          pop_i,
    output mon_evt_t      head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o,
    output logic          drop_o
);

    mon_evt_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            full_s, do_push_s, do_pop_s;

    assign full_s    = (count_q == CW'(DEPTH));
    assign do_pop_s  = pop_i && (count_q != {CW{1'b0}});
    // A pop frees the slot the push lands in, so full does not block a simultaneous push.
    assign do_push_s = push_i && (!full_s || do_pop_s);
    assign drop_o    = push_i && full_s && !do_pop_s;

    assign head_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != {CW{1'b0}});
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (do_push_s && !do_pop_s) begin
            count_d = count_q + CW'(1);
        end else if (do_pop_s && !do_push_s) begin
            count_d = count_q - CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/monitor_bus_capture.sv
// Monitor interface receiver: synchronises strobes and MWL, filters glitches,
// latches per-strobe shadows and queues capture events.
module monitor_bus_capture
    import monitor_pkg::*;
#(
    parameter  int DEPTH       = 16,
    parameter  int MIN_HIGH    = 2,
    parameter  int SYNC_STAGES = 2,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic                 SIM_CLK,
    input  logic                 SIM_RST,
    input  logic [NUM_STB-1:0]   STB,
    input  logic [15:0]          MWL,
    input  logic [3:0]           reg_sel,
    output logic [15:0]          reg_data,
    monitor_bus_capture_if.master evt,
    output logic [CW-1:0]        evt_count,
    output logic                 ovf,
    input  logic                 clear_ovf
);

    localparam int CNTW = $clog2(MIN_HIGH + 1);

    logic [NUM_STB-1:0] stb_sync_q [SYNC_STAGES];
    logic [15:0]        mwl_sync_q [SYNC_STAGES];
    logic [15:0]        mwl_d_q;
    logic [CNTW-1:0]    cnt_q [NUM_STB];
    logic [CNTW-1:0]    cnt_d [NUM_STB];
    logic [15:0]        shadow_q [NUM_STB];
    logic               ovf_q, ovf_d;
    logic [15:0]        reg_data_q, reg_data_d;

    logic [NUM_STB-1:0] stb_s, accept_s;
    logic [15:0]        mwl_s;
    mon_evt_t           push_evt_s, head_s;
    logic               fifo_valid_s, drop_s;
    logic [CW-1:0]      fifo_count_s;
    logic [4:0]         count5_s;

    assign stb_s = stb_sync_q[SYNC_STAGES-1];
    assign mwl_s = mwl_sync_q[SYNC_STAGES-1];

    // Synchroniser chains plus one extra register holding the previous synced bus value.
    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                stb_sync_q[s] <= {NUM_STB{1'b0}};
                mwl_sync_q[s] <= 16'h0000;
            end
            mwl_d_q <= 16'h0000;
        end else begin
            stb_sync_q[0] <= STB;
            mwl_sync_q[0] <= MWL;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                stb_sync_q[s] <= stb_sync_q[s-1];
                mwl_sync_q[s] <= mwl_sync_q[s-1];
            end
            mwl_d_q <= mwl_s;
        end
    end

    // A nonzero count implies the previous cycle was high, so low-with-full-count is the accepted fall.
    always_comb begin
        for (int i = 0; i < NUM_STB; i++) begin
            cnt_d[i]    = {CNTW{1'b0}};
            accept_s[i] = 1'b0;
            if (stb_s[i]) begin
                if (cnt_q[i] == CNTW'(MIN_HIGH)) begin
                    cnt_d[i] = cnt_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNTW'(1);
                end
            end else begin
                cnt_d[i]    = {CNTW{1'b0}};
                accept_s[i] = (cnt_q[i] == CNTW'(MIN_HIGH));
            end
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            for (int i = 0; i < NUM_STB; i++) begin
                cnt_q[i]    <= {CNTW{1'b0}};
                shadow_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < NUM_STB; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (accept_s[i]) begin
                    shadow_q[i] <= mwl_d_q;
                end
            end
        end
    end

    assign push_evt_s.mask = accept_s;
    assign push_evt_s.data = mwl_d_q;

    mon_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (SIM_CLK),
        .rst_n       (SIM_RST),
        .push_i      (|accept_s),
        .push_data_i (push_evt_s),
        .pop_i       (evt.evt_ready),
        .head_o      (head_s),
        .valid_o     (fifo_valid_s),
        .count_o     (fifo_count_s),
        .drop_o      (drop_s)
    );

    generate
        if (CW >= 5) begin : g_cnt_trunc
            assign count5_s = fifo_count_s[4:0];
        end else begin : g_cnt_ext
            assign count5_s = {{(5-CW){1'b0}}, fifo_count_s};
        end
    endgenerate

    always_comb begin
        ovf_d      = ovf_q;
        reg_data_d = 16'h0000;
        if (drop_s) begin
            ovf_d = 1'b1;
        end else if (clear_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (reg_sel == STATUS_SEL) begin
            reg_data_d = {ovf_q, fifo_valid_s, 9'b0_0000_0000, count5_s};
        end else begin
            for (int i = 0; i < NUM_STB; i++) begin
                if (reg_sel == 4'(i)) begin
                    reg_data_d = shadow_q[i];
                end
            end
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            ovf_q      <= 1'b0;
            reg_data_q <= 16'h0000;
        end else begin
            ovf_q      <= ovf_d;
            reg_data_q <= reg_data_d;
        end
    end

    assign evt.evt_valid = fifo_valid_s;
    assign evt.evt_mask  = head_s.mask;
    assign evt.evt_data  = head_s.data;
    assign evt_count     = fifo_count_s;
    assign ovf           = ovf_q;
    assign reg_data      = reg_data_q;

endmodule

// File: tb/tb_monitor_bus_capture.sv
// Scoreboard bench for monitor_bus_capture: directed strobe pulses, queued expected events.
module tb_monitor_bus_capture;
    import monitor_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [14:0]   stb = 15'h0000;
    logic [15:0]   mwl = 16'h0000;
    logic [3:0]    sel = 4'h0;
    logic [15:0]   reg_data;
    logic [CW-1:0] evt_count;
    logic          ovf;
    logic          clr = 1'b0;

    monitor_bus_capture_if bus ();

    monitor_bus_capture #(.DEPTH(DEPTH), .MIN_HIGH(2), .SYNC_STAGES(2)) dut (
        .SIM_CLK   (clk),
        .SIM_RST   (rst_n),
        .STB       (stb),
        .MWL       (mwl),
        .reg_sel   (sel),
        .reg_data  (reg_data),
        .evt       (bus),
        .evt_count (evt_count),
        .ovf       (ovf),
        .clear_ovf (clr)
    );

    always #5 clk = ~clk;

    mon_evt_t sb [$];
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every accepted head must match the oldest expected event.
    always @(negedge clk) begin
        if (bus.evt_valid === 1'b1 && bus.evt_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_event actual=%h/%h required=none", bus.evt_mask, bus.evt_data);
            end else begin
                mon_evt_t e;
                e = sb.pop_front();
                chk("evt_mask", 32'(bus.evt_mask), 32'(e.mask));
                chk("evt_data", 32'(bus.evt_data), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse(input logic [14:0] m, input logic [15:0] v, input int n,
                         input bit expect_evt, input bit pop_on_accept);
        mon_evt_t e;
        mwl = v;
        stb = m;
        repeat (n) tick();
        stb = 15'h0000;
        if (expect_evt) begin
            e.mask = m;
            e.data = v;
            sb.push_back(e);
        end
        tick();
        tick();
        if (pop_on_accept) bus.evt_ready = 1'b1;
        tick();
        if (pop_on_accept) bus.evt_ready = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [3:0] s, input logic [15:0] exp, input string name);
        sel = s;
        tick();
        tick();
        chk(name, 32'(reg_data), 32'(exp));
    endtask

    task automatic drain();
        bus.evt_ready = 1'b1;
        for (int k = 0; k < 200 && evt_count != 0; k++) tick();
        tick();
        chk("drain_count", 32'(evt_count), 32'd0);
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bus.evt_ready = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_evt_valid", 32'(bus.evt_valid), 32'd0);
        chk("rst_evt_count", 32'(evt_count), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_reg_data", 32'(reg_data), 32'd0);
        chk("rst_evt_mask", 32'(bus.evt_mask), 32'd0);
        chk("rst_evt_data", 32'(bus.evt_data), 32'd0);

        // MWAG capture with latency check
        mwl = 16'o12345;
        stb = 15'h0002;
        repeat (4) tick();
        stb = 15'h0000;
        sb.push_back('{mask: 15'h0002, data: 16'o12345});
        tick();
        tick();
        chk("lat_not_yet", 32'(bus.evt_valid), 32'd0);
        tick();
        chk("lat_valid", 32'(bus.evt_valid), 32'd1);
        rd(4'd1, 16'o12345, "shadow1");
        drain();

        // single-cycle MWLG glitch
        pulse(15'h0004, 16'hABCD, 1, 1'b0, 1'b0);
        chk("glitch_count", 32'(evt_count), 32'd0);
        chk("glitch_valid", 32'(bus.evt_valid), 32'd0);
        rd(4'd2, 16'h0000, "shadow2_glitch");

        // MWG + MWBG together
        pulse(15'h0021, 16'h7FFF, 3, 1'b1, 1'b0);
        rd(4'd0, 16'h7FFF, "shadow0");
        rd(4'd5, 16'h7FFF, "shadow5");
        chk("dual_sb_empty", 32'(sb.size()), 32'd0);

        // overflow with 17 MWQG pulses
        bus.evt_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            pulse(15'h0008, 16'h1000 + 16'(k), 3, k < 16, 1'b0);
        end
        chk("ovf_count", 32'(evt_count), 32'd16);
        chk("ovf_flag", 32'(ovf), 32'd1);
        rd(4'd3, 16'h1010, "shadow3_17th");
        rd(4'hF, 16'hC010, "status_full_ovf");
        drain();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("ovf_cleared", 32'(ovf), 32'd0);

        // full FIFO, push and pop in the same cycle
        bus.evt_ready = 1'b0;
        for (int k = 0; k < 16; k++) begin
            pulse(15'h0008, 16'h2000 + 16'(k), 3, 1'b1, 1'b0);
        end
        chk("full_count", 32'(evt_count), 32'd16);
        pulse(15'h0008, 16'h2010, 3, 1'b1, 1'b1);
        chk("pushpop_count", 32'(evt_count), 32'd16);
        chk("pushpop_no_ovf", 32'(ovf), 32'd0);
        chk("pushpop_head", 32'(bus.evt_data), 32'h2001);
        rd(4'd3, 16'h2010, "shadow3_pushpop");
        drain();

        // reset mid-pulse on MRAG, released with one high cycle left
        mwl = 16'h5555;
        stb = 15'h0800;
        repeat (5) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        stb = 15'h0000;
        repeat (6) tick();
        chk("rstmid_valid", 32'(bus.evt_valid), 32'd0);
        chk("rstmid_count", 32'(evt_count), 32'd0);
        rd(4'd11, 16'h0000, "shadow11_rstmid");
        rd(4'hF, 16'h0000, "status_rstmid");
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
